prio_code_decoder: RTL and testbench

Streaming decoder for the 4-to-2 priority-encoder codes used in this design.
- Accepts a CODE_W-bit priority code over a valid/ready handshake.
- Returns both the canonical one-hot request pattern and the thermometer mask for that code.
- Sits downstream of the priority encoder. Round-trips its codes: re-encoding out_onehot with the priority encoder yields the original code.
- A 2-entry output buffer decouples producer and consumer. An optional per-code hit counter supports debug.

---
 rtl/prio_code_decoder_pkg.sv | 27 ++
 rtl/prio_code_expand.sv | 23 ++
 rtl/prio_code_decoder.sv | 100 ++++++++++
 tb/tb_prio_code_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/prio_code_decoder_pkg.sv
// Shared constants for the priority-code decoder: pattern width, FIFO depth and
// occupancy encoding, plus the occupancy next-state helper.
package prio_code_decoder_pkg;

   localparam int unsigned DEC_CODE_W = 2;
   localparam int unsigned PAT_W      = 2 ** DEC_CODE_W;
   localparam int unsigned DEC_DEPTH  = 2;

   localparam logic [1:0] CNT_EMPTY = 2'd0;
   localparam logic [1:0] CNT_ONE   = 2'd1;
   localparam logic [1:0] CNT_FULL  = 2'd2;

   // Push and pop together leave the occupancy unchanged.
   function automatic logic [1:0] dec_count_next(input logic [1:0] count,
                                                 input logic       push,
                                                 input logic       pop);
      logic [1:0] nxt;
      nxt = count;
      case ({push, pop})
         2'b10:   nxt = count + 2'd1;
         2'b01:   nxt = count - 2'd1;
         default: nxt = count;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/prio_code_expand.sv
// Combinational expansion of a priority code into its one-hot request pattern
// and its thermometer mask.
module prio_code_expand
   import prio_code_decoder_pkg::*;
#(
   parameter int unsigned CODE_W = DEC_CODE_W,
   localparam int unsigned PatW  = 2 ** CODE_W
) (
   input  logic [CODE_W-1:0] code,
   output logic [PatW-1:0]   onehot,
   output logic [PatW-1:0]   thermo
);

   always_comb begin
      onehot = '0;
      thermo = '0;
      for (int unsigned i = 0; i < PatW; i++) begin
         onehot[i] = (CODE_W'(i) == code);
         thermo[i] = (CODE_W'(i) <= code);
      end
   end

endmodule

// File: rtl/prio_code_decoder.sv
// Streaming priority-code decoder with a 2-entry output buffer.
// Define DEC_STATS_EN to build the saturating per-code hit counters.
module prio_code_decoder
   import prio_code_decoder_pkg::*;
#(
   parameter int unsigned CODE_W = DEC_CODE_W,
   parameter int unsigned CNT_W  = 8,
   localparam int unsigned PatW  = 2 ** CODE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PatW-1:0]   out_onehot,
   output logic [PatW-1:0]   out_thermo,
   output logic [CODE_W-1:0] out_code,
   input  logic [CODE_W-1:0] stat_sel,
   output logic [CNT_W-1:0]  stat_count
);

   typedef struct packed {
      logic [CODE_W-1:0] code;
      logic [PatW-1:0]   onehot;
      logic [PatW-1:0]   thermo;
   } entry_t;

   entry_t head_q, head_d, tail_q, tail_d, wr_entry;
   logic [$clog2(DEC_DEPTH+1)-1:0] count_q, count_d;
   logic push, pop;

   prio_code_expand #(
      .CODE_W (CODE_W)
   ) u_expand (
      .code   (in_code),
      .onehot (wr_entry.onehot),
      .thermo (wr_entry.thermo)
   );
   assign wr_entry.code = in_code;

   // in_ready comes from registered state only, so a full buffer refuses a
   // push even when the head is popped in the same cycle.
   assign in_ready  = !rst && (count_q != CNT_FULL);
   assign out_valid = (count_q != CNT_EMPTY);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = dec_count_next(count_q, push, pop);
      case (count_q)
         CNT_EMPTY: if (push) head_d = wr_entry;
         CNT_ONE: begin
            if (push && pop) head_d = wr_entry;
            else if (push)   tail_d = wr_entry;
         end
         CNT_FULL:  if (pop) head_d = tail_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= CNT_EMPTY;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Mask the head so an empty buffer never shows stale data.
   assign out_onehot = out_valid ? head_q.onehot : '0;
   assign out_thermo = out_valid ? head_q.thermo : '0;
   assign out_code   = out_valid ? head_q.code   : '0;

`ifdef DEC_STATS_EN
   logic [CNT_W-1:0] hits_q [PatW];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(PatW); i++) hits_q[i] <= '0;
      end else if (push && (hits_q[in_code] != {CNT_W{1'b1}})) begin
         hits_q[in_code] <= hits_q[in_code] + CNT_W'(1);
      end
   end

   assign stat_count = hits_q[stat_sel];
`else
   logic unused_stat_sel;
   assign unused_stat_sel = ^stat_sel;
   assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_prio_code_decoder.sv
// Bench for prio_code_decoder: directed vector table, stats saturation sequence
// and randomized traffic against a queue-based reference model.
module tb_prio_code_decoder;

   localparam int unsigned CW = 2;
   localparam int unsigned PW = 4;
   localparam int unsigned NW = 2;
   localparam int          HIT_MAX = (1 << NW) - 1;
`ifdef DEC_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk, rst, in_valid, in_ready, out_valid, out_ready;
   logic [CW-1:0] in_code, out_code, stat_sel;
   logic [PW-1:0] out_onehot, out_thermo;
   logic [NW-1:0] stat_count;

   prio_code_decoder #(
      .CODE_W (CW),
      .CNT_W  (NW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_code    (in_code),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_onehot (out_onehot),
      .out_thermo (out_thermo),
      .out_code   (out_code),
      .stat_sel   (stat_sel),
      .stat_count (stat_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   int q[$];
   int hits[PW];
   bit m_push, m_pop, m_hold;

   typedef struct {
      bit         rst;
      bit         iv;
      logic [1:0] code;
      bit         ordy;
      bit         rdy;
      bit         ov;
      logic [3:0] oh;
      logic [3:0] th;
      logic [1:0] oc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit r, bit iv, logic [1:0] c, bit ordy, bit rdy, bit ov,
                               logic [3:0] oh, logic [3:0] th, logic [1:0] oc);
      vec_t v;
      v.rst = r; v.iv = iv; v.code = c; v.ordy = ordy;
      v.rdy = rdy; v.ov = ov; v.oh = oh; v.th = th; v.oc = oc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Priority encoder: index of the highest set bit.
   function automatic int reencode(input logic [PW-1:0] oh);
      int r;
      r = -1;
      for (int i = 0; i < int'(PW); i++) if (oh[i]) r = i;
      return r;
   endfunction

   task automatic check_model();
      bit ev, er;
      int hc;
      @(negedge clk);
      ev = (q.size() != 0);
      hc = ev ? q[0] : 0;
      er = !rst && (q.size() != 2);
      chk("in_ready", 32'(in_ready), 32'(er));
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("out_code", 32'(out_code), ev ? hc : 0);
      chk("out_onehot", 32'(out_onehot), ev ? (1 << hc) : 0);
      chk("out_thermo", 32'(out_thermo), ev ? ((1 << (hc + 1)) - 1) : 0);
      if (ev) chk("reencode", reencode(out_onehot), hc);
      chk("stat_count", 32'(stat_count), STATS ? hits[stat_sel] : 0);
      m_push = in_valid && er;
      m_pop  = ev && out_ready;
      m_hold = in_valid && !er && !rst;
   endtask

   task automatic advance();
      @(posedge clk);
      if (rst) begin
         q.delete();
         for (int i = 0; i < int'(PW); i++) hits[i] = 0;
      end else begin
         if (m_pop) void'(q.pop_front());
         if (m_push) begin
            q.push_back(int'(in_code));
            if (STATS && hits[in_code] < HIT_MAX) hits[in_code]++;
         end
      end
      #1;
   endtask

   initial begin
      // reset hold, then exhaustive mapping back-to-back
      vecs.push_back(mk(1, 1, 3, 1, 0, 0, 4'h0, 4'h0, 0));
      vecs.push_back(mk(1, 1, 3, 1, 0, 0, 4'h0, 4'h0, 0));
      vecs.push_back(mk(1, 1, 3, 1, 0, 0, 4'h0, 4'h0, 0));
      vecs.push_back(mk(0, 1, 0, 1, 1, 0, 4'h0, 4'h0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 1, 1, 4'h1, 4'h1, 0));
      vecs.push_back(mk(0, 1, 2, 1, 1, 1, 4'h2, 4'h3, 1));
      vecs.push_back(mk(0, 1, 3, 1, 1, 1, 4'h4, 4'h7, 2));
      vecs.push_back(mk(0, 0, 0, 1, 1, 1, 4'h8, 4'hf, 3));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 4'h0, 4'h0, 0));
      // backpressure: fill, refuse third offer, then drain
      vecs.push_back(mk(0, 1, 2, 0, 1, 0, 4'h0, 4'h0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 4'h4, 4'h7, 2));
      vecs.push_back(mk(0, 1, 3, 0, 0, 1, 4'h4, 4'h7, 2));
      vecs.push_back(mk(0, 1, 3, 1, 0, 1, 4'h4, 4'h7, 2));
      vecs.push_back(mk(0, 0, 0, 1, 1, 1, 4'h2, 4'h3, 1));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 4'h0, 4'h0, 0));
      // simultaneous push/pop at one entry
      vecs.push_back(mk(0, 1, 0, 0, 1, 0, 4'h0, 4'h0, 0));
      vecs.push_back(mk(0, 1, 3, 1, 1, 1, 4'h1, 4'h1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 4'h8, 4'hf, 3));
      // reset with two entries buffered
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 4'h8, 4'hf, 3));
      vecs.push_back(mk(1, 1, 2, 1, 0, 1, 4'h8, 4'hf, 3));
      vecs.push_back(mk(0, 1, 3, 0, 1, 0, 4'h0, 4'h0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 1, 4'h8, 4'hf, 3));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 4'h0, 4'h0, 0));

      rst = 1'b1; in_valid = 1'b1; in_code = '0; out_ready = 1'b1; stat_sel = '0;
      @(posedge clk);
      #1;
      q.delete();
      for (int i = 0; i < int'(PW); i++) hits[i] = 0;

      foreach (vecs[k]) begin
         rst = vecs[k].rst; in_valid = vecs[k].iv; in_code = vecs[k].code;
         out_ready = vecs[k].ordy; stat_sel = 2'($urandom);
         check_model();
         chk($sformatf("vec%0d in_ready", k), 32'(in_ready), 32'(vecs[k].rdy));
         chk($sformatf("vec%0d out_valid", k), 32'(out_valid), 32'(vecs[k].ov));
         chk($sformatf("vec%0d out_onehot", k), 32'(out_onehot), 32'(vecs[k].oh));
         chk($sformatf("vec%0d out_thermo", k), 32'(out_thermo), 32'(vecs[k].th));
         chk($sformatf("vec%0d out_code", k), 32'(out_code), 32'(vecs[k].oc));
         advance();
      end

      // hit counter saturation: five pushes of code 01
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_code = 2'b01; out_ready = 1'b1; stat_sel = 2'b01;
         check_model();
         advance();
      end
      in_valid = 1'b0; stat_sel = 2'b01;
      check_model();
      chk("stat_sat", 32'(stat_count), STATS ? 3 : 0);
      stat_sel = 2'b00;
      #1;
      chk("stat_zero", 32'(stat_count), 0);
      advance();

      // randomized traffic with occasional resets
      m_hold = 1'b0;
      for (int n = 0; n < 500; n++) begin
         rst = ($urandom_range(0, 39) == 0);
         if (!m_hold) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_code  = 2'($urandom);
         end
         out_ready = ($urandom_range(0, 2) != 0);
         stat_sel  = 2'($urandom);
         check_model();
         advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
